// File: rtl/seq_gen.sv
// seq_gen: serial pattern transmitter.
// Captures a parallel pattern of programmable length and shifts it out
// MSB-first, one bit per clock, with a repeat count and an optional idle
// gap between repetitions. Start/busy/done handshake plus abort.
module seq_gen #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [3:0]       reps,
  input  logic [3:0]       gap,
  input  logic             abort,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    GAP   = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t           state, state_nx;

  // captured configuration
  logic [WIDTH-1:0] pat_q;
  logic [IDX_W-1:0] tidx_q, tidx_nx;   // index of first bit sent (L-1)
  logic [3:0]       gap_q, gap_nx;

  // progress counters
  logic [IDX_W-1:0] idx_q, idx_nx;     // index of bit currently on dout
  logic [3:0]       reps_q, reps_nx;   // repetitions still to send
  logic [3:0]       gcnt_q, gcnt_nx;   // gap cycles still to spend

  logic             dout_nx, valid_nx, busy_nx, done_nx;
  logic             cap;
  logic [IDX_W-1:0] len_top;
  logic [IDX_W-1:0] idx_m1;

  // Effective length L: 0 and anything above WIDTH mean WIDTH.
  // Returns L-1, the index of the first bit to transmit.
  function automatic logic [IDX_W-1:0] top_idx(input logic [LEN_W-1:0] l);
    logic [LEN_W-1:0] e;
    if (l == '0 || l > LEN_W'(WIDTH)) e = LEN_W'(WIDTH);
    else                               e = l;
    return IDX_W'(e - LEN_W'(1));
  endfunction

  assign len_top = top_idx(len);
  assign idx_m1  = idx_q - IDX_W'(1);

  // Next-state and next-output logic; abort overrides any non-idle activity.
  always_comb begin
    state_nx = state;
    tidx_nx  = tidx_q;
    gap_nx   = gap_q;
    idx_nx   = idx_q;
    reps_nx  = reps_q;
    gcnt_nx  = gcnt_q;
    dout_nx  = dout;
    valid_nx = dout_valid;
    busy_nx  = busy;
    done_nx  = done;
    cap      = 1'b0;

    case (state)
      IDLE: begin
        dout_nx  = 1'b0;
        valid_nx = 1'b0;
        busy_nx  = 1'b0;
        done_nx  = 1'b0;
        // start together with abort is dropped
        if (start && !abort) begin
          cap      = 1'b1;
          tidx_nx  = len_top;
          idx_nx   = len_top;
          reps_nx  = reps;
          gap_nx   = gap;
          dout_nx  = pattern[len_top];
          valid_nx = 1'b1;
          busy_nx  = 1'b1;
          state_nx = SHIFT;
        end
      end

      SHIFT: begin
        if (idx_q != '0) begin
          idx_nx  = idx_m1;
          dout_nx = pat_q[idx_m1];
        end else if (reps_q != 4'd0) begin
          reps_nx = reps_q - 4'd1;
          if (gap_q != 4'd0) begin
            gcnt_nx  = gap_q - 4'd1;
            dout_nx  = 1'b0;
            valid_nx = 1'b0;
            state_nx = GAP;
          end else begin
            // back-to-back: reload the first bit on the same edge
            idx_nx  = tidx_q;
            dout_nx = pat_q[tidx_q];
          end
        end else begin
          dout_nx  = 1'b0;
          valid_nx = 1'b0;
          busy_nx  = 1'b0;
          done_nx  = 1'b1;
          state_nx = DONE;
        end
      end

      GAP: begin
        if (gcnt_q == 4'd0) begin
          idx_nx   = tidx_q;
          dout_nx  = pat_q[tidx_q];
          valid_nx = 1'b1;
          state_nx = SHIFT;
        end else begin
          gcnt_nx = gcnt_q - 4'd1;
        end
      end

      DONE: begin
        done_nx  = 1'b0;
        state_nx = IDLE;
      end

      default: state_nx = IDLE;
    endcase

    if (abort && state != IDLE) begin
      state_nx = IDLE;
      dout_nx  = 1'b0;
      valid_nx = 1'b0;
      busy_nx  = 1'b0;
      done_nx  = 1'b0;
      idx_nx   = '0;
      reps_nx  = 4'd0;
      gcnt_nx  = 4'd0;
    end
  end

  // State, counters and registered outputs; reset clears everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      tidx_q     <= '0;
      gap_q      <= 4'd0;
      idx_q      <= '0;
      reps_q     <= 4'd0;
      gcnt_q     <= 4'd0;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nx;
      tidx_q     <= tidx_nx;
      gap_q      <= gap_nx;
      idx_q      <= idx_nx;
      reps_q     <= reps_nx;
      gcnt_q     <= gcnt_nx;
      dout       <= dout_nx;
      dout_valid <= valid_nx;
      busy       <= busy_nx;
      done       <= done_nx;
    end
  end

  // Pattern capture register; data only, no reset needed.
  always_ff @(posedge clock) begin
    if (cap) pat_q <= pattern;
  end

endmodule

// File: tb/tb_seq_gen.sv
// Bench for seq_gen: table of directed transfers, hand-written abort/reset
// sequences, and randomized transfers against a behavioural model.
module tb_seq_gen;
  localparam int WIDTH = 8;
  localparam int LEN_W = 4;

  logic       clk = 1'b0;
  logic       reset, start, abort;
  logic [7:0] pattern;
  logic [3:0] len, reps, gap;
  logic       dout, dout_valid, busy, done;

  always #5 clk = ~clk;

  seq_gen #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clock(clk), .reset(reset), .start(start), .pattern(pattern),
    .len(len), .reps(reps), .gap(gap), .abort(abort),
    .dout(dout), .dout_valid(dout_valid), .busy(busy), .done(done)
  );

  int total = 0;
  int bad   = 0;
  logic [3:0] exp_q[$];   // per-cycle {dout, dout_valid, busy, done}

  typedef struct {
    logic [7:0]  p;
    logic [3:0]  l, r, g;
    logic [63:0] bits;    // serial stream, first bit most significant
    int          n;       // number of valid bits
    int          dcyc;    // cycle of the done pulse
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int eff_len(input logic [3:0] l);
    if (l == 4'd0 || int'(l) > WIDTH) return WIDTH;
    return int'(l);
  endfunction

  // Model: reps+1 copies of the top L bits, gap idle cycles in between,
  // then a done cycle and an idle cycle.
  task automatic build(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r, input logic [3:0] g);
    int L;
    L = eff_len(l);
    exp_q.delete();
    for (int k = 0; k <= int'(r); k++) begin
      for (int b = L - 1; b >= 0; b--) exp_q.push_back({p[b], 3'b110});
      if (k < int'(r))
        for (int j = 0; j < int'(g); j++) exp_q.push_back(4'b0010);
    end
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0000);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] obs();
    return {dout, dout_valid, busy, done};
  endfunction

  // Start a transfer on the next edge and follow it to idle.
  task automatic xfer(input string name, input logic [7:0] p, input logic [3:0] l,
                      input logic [3:0] r, input logic [3:0] g,
                      output logic [63:0] bits, output int nvalid, output int nbusy,
                      output int dcyc, output int ndet);
    logic [3:0] det;
    build(p, l, r, g);
    pattern = p; len = l; reps = r; gap = g; start = 1'b1;
    step();
    start = 1'b0;
    pattern = ~p; len = l + 4'd3; reps = r + 4'd1; gap = g + 4'd2;
    bits = '0; nvalid = 0; nbusy = 0; dcyc = -1; ndet = 0; det = 4'd0;
    for (int c = 0; c < exp_q.size(); c++) begin
      chk($sformatf("%s cyc%0d", name, c + 1), 64'(obs()), 64'(exp_q[c]));
      if (dout_valid) begin
        bits = {bits[62:0], dout};
        nvalid++;
        det = {det[2:0], dout};
        if (det == 4'b1011) ndet++;
      end
      if (busy) nbusy++;
      if (done && dcyc < 0) dcyc = c + 1;
      step();
    end
    chk($sformatf("%s state_idle", name), 64'(dut.state), 64'd0);
  endtask

  logic [63:0] bits;
  int nv, nb, dc, nd, L;
  logic [7:0] rp;
  logic [3:0] rl, rr, rg;

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    pattern = 8'h00; len = 4'd0; reps = 4'd0; gap = 4'd0;
    step(); step();
    chk("reset outputs", 64'(obs()), 64'd0);
    chk("reset state", 64'(dut.state), 64'd0);
    reset = 1'b0;
    step();
    chk("idle no start", 64'(obs()), 64'd0);

    tbl[0] = '{8'h0B, 4'd4,  4'd0,  4'd0, 64'b1011,         4,  5};
    tbl[1] = '{8'h0B, 4'd4,  4'd1,  4'd0, 64'b10111011,     8,  9};
    tbl[2] = '{8'h0B, 4'd4,  4'd2,  4'd3, 64'b101110111011, 12, 19};
    tbl[3] = '{8'hA5, 4'd0,  4'd0,  4'd0, 64'b10100101,     8,  9};
    tbl[4] = '{8'h01, 4'd1,  4'd0,  4'd0, 64'b1,            1,  2};
    tbl[5] = '{8'hA5, 4'd12, 4'd0,  4'd0, 64'b10100101,     8,  9};
    tbl[6] = '{8'h80, 4'd1,  4'd0,  4'd0, 64'b0,            1,  2};
    tbl[7] = '{8'h01, 4'd1,  4'd15, 4'd0, 64'hFFFF,         16, 17};
    tbl[8] = '{8'h06, 4'd3,  4'd1,  4'd1, 64'b110110,       6,  8};

    for (int i = 0; i < 9; i++) begin
      xfer($sformatf("vec%0d", i), tbl[i].p, tbl[i].l, tbl[i].r, tbl[i].g, bits, nv, nb, dc, nd);
      chk($sformatf("vec%0d bits", i), bits, tbl[i].bits);
      chk($sformatf("vec%0d nvalid", i), 64'(nv), 64'(tbl[i].n));
      chk($sformatf("vec%0d done_cycle", i), 64'(dc), 64'(tbl[i].dcyc));
      if (i == 1) chk("loopback detections", 64'(nd), 64'd2);
    end

    // start re-asserted on edges 2-3 with a different pattern is ignored
    build(8'h0B, 4'd4, 4'd0, 4'd0);
    pattern = 8'h0B; len = 4'd4; reps = 4'd0; gap = 4'd0; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 6; c++) begin
      chk($sformatf("restart cyc%0d", c + 1), 64'(obs()), 64'(exp_q[c]));
      if (c == 1 || c == 2) begin start = 1'b1; pattern = 8'hFF; len = 4'd0; end
      else start = 1'b0;
      step();
    end
    start = 1'b0;

    // abort at edge 2: idle from cycle 3, no done pulse
    pattern = 8'h0B; len = 4'd4; reps = 4'd2; gap = 4'd0; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 6; c++) begin
      case (c)
        0:       chk("abort cyc1", 64'(obs()), 64'b1110);
        1:       chk("abort cyc2", 64'(obs()), 64'b0110);
        default: chk($sformatf("abort cyc%0d", c + 1), 64'(obs()), 64'd0);
      endcase
      if (c == 2) chk("abort state", 64'(dut.state), 64'd0);
      abort = (c == 1);
      step();
    end
    abort = 1'b0;

    // start and abort together in idle: start dropped
    pattern = 8'hFF; len = 4'd8; start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    chk("start+abort outputs", 64'(obs()), 64'd0);
    chk("start+abort state", 64'(dut.state), 64'd0);
    step();

    // reset at edge 3 of a gapped transfer, new start at edge 6
    build(8'h0B, 4'd4, 4'd2, 4'd3);
    pattern = 8'h0B; len = 4'd4; reps = 4'd2; gap = 4'd3; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (c < 3) chk($sformatf("rst cyc%0d", c + 1), 64'(obs()), 64'(exp_q[c]));
      else       chk($sformatf("rst cyc%0d", c + 1), 64'(obs()), 64'd0);
      if (c == 3) begin
        chk("rst state", 64'(dut.state), 64'd0);
        chk("rst reps counter", 64'(dut.reps_q), 64'd0);
      end
      reset = (c == 2);
      step();
    end
    reset = 1'b0;
    chk("rst cyc6", 64'(obs()), 64'd0);
    xfer("after_rst", 8'h0B, 4'd4, 4'd0, 4'd0, bits, nv, nb, dc, nd);
    chk("after_rst bits", bits, 64'b1011);

    // randomized transfers
    for (int i = 0; i < 40; i++) begin
      rp = 8'($urandom);
      rl = 4'($urandom_range(0, 15));
      rr = 4'($urandom_range(0, 4));
      rg = 4'($urandom_range(0, 5));
      L  = eff_len(rl);
      xfer($sformatf("rnd%0d", i), rp, rl, rr, rg, bits, nv, nb, dc, nd);
      chk($sformatf("rnd%0d nvalid", i), 64'(nv), 64'(L * (int'(rr) + 1)));
      chk($sformatf("rnd%0d nbusy", i), 64'(nb), 64'(L * (int'(rr) + 1) + int'(rg) * int'(rr)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seq_gen.md
Name: seq_gen

Overview:
- Serial pattern transmitter; the transmit-side counterpart of the sequence detector.
- Loads a parallel pattern of programmable length and shifts it out MSB-first on a single-bit line, one bit per clock.
- Supports a repeat count and an optional idle gap between repetitions, so it can drive overlapping or non-overlapping streams (e.g. 1011 1011) directly into a detector's din.
- Start/busy/done handshake with an abort input.

Parameters:
- WIDTH, 8, maximum pattern length in bits.
- LEN_W, 4, width of the len input. Must hold the value WIDTH.

Ports:
- clock  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset; highest priority.
- start  input  1  request to transmit; sampled only in IDLE.
- pattern  input  WIDTH  pattern bits; bit [len-1] is sent first, bit [0] last.
- len  input  LEN_W  number of bits per repetition. 0 means WIDTH. Values above WIDTH are clamped to WIDTH.
- reps  input  4  extra repetitions; total transmissions = reps+1.
- gap  input  4  idle cycles inserted between repetitions. 0 means back-to-back.
- abort  input  1  synchronous cancel of an in-progress transfer.
- dout  output  1  serial data, registered.
- dout_valid  output  1  high on every cycle dout carries a pattern bit, registered.
- busy  output  1  high in SHIFT and GAP.
- done  output  1  one-cycle pulse on normal completion.

Behaviour:
- Reset values: dout=0, dout_valid=0, busy=0, done=0, state=IDLE, all counters=0.
- State machine: 2-bit register named state. Encoding: IDLE=00, SHIFT=01, GAP=10, DONE=11. The register is kept as a named reg so benches can probe it hierarchically.
- Priority each edge: reset > abort > start > normal operation.

IDLE:
- On an edge where start=1: capture pattern, effective length L (len==0 or len>WIDTH gives WIDTH), reps, gap.
- Same edge: state<=SHIFT, dout<=pattern[L-1], dout_valid<=1, busy<=1.
- Latency: the first bit is visible in the cycle immediately after the accepting edge.
- Without start: outputs stay 0.

SHIFT:
- Each edge advances the bit index by one. Exactly L consecutive cycles have dout_valid=1 per repetition.
- After the last bit (index 0), with repetitions remaining:
  - gap>0: state<=GAP, dout<=0, dout_valid<=0.
  - gap=0: load pattern[L-1] again on the same edge, giving a seamless stream.
- After the last bit with no repetitions remaining: state<=DONE, dout<=0, dout_valid<=0, busy<=0, done<=1.

GAP:
- Exactly gap cycles with dout=0, dout_valid=0, busy=1.
- On the final gap edge: state<=SHIFT and dout<=pattern[L-1].

DONE:
- Lasts one cycle with done=1. Next edge: state<=IDLE, done<=0.
- start in DONE is ignored; the next accept is possible from IDLE.

Boundary conditions:
- start while busy or in DONE is ignored. Captured values are unaffected by later changes to the inputs.
- abort in SHIFT, GAP or DONE: next edge forces state=IDLE, dout=0, dout_valid=0, busy=0, done=0. No done pulse is produced.
- abort in IDLE has no effect. start and abort together in IDLE: abort wins, start is dropped.
- reset mid-transfer: same result as abort, plus all counters are cleared.
- len=1: a single valid cycle per repetition.
- reps=15: 16 transmissions. The counter must not wrap early.
- Total valid cycles per transfer = L*(reps+1). Total busy cycles = L*(reps+1) + gap*reps.

Test Plan:
1. pattern=8'b0000_1011, len=4, reps=0, gap=0; start pulse at cycle 0.
   - dout = 1,0,1,1 on cycles 1-4 with dout_valid=1.
   - done=1 on cycle 5; busy=0 on cycle 5; IDLE on cycle 6.
2. Loopback into the sequence detector: pattern 1011, len=4, reps=1, gap=0.
   - dout streams 10111011 on cycles 1-8.
   - Detector dout asserts once per completed 1011.
   - seq_gen done on cycle 9.
3. Gap insertion: pattern 1011, len=4, reps=2, gap=3.
   - Valid bits on cycles 1-4, 8-11 and 15-18; dout_valid=0 and busy=1 in cycles 5-7 and 12-14.
   - done on cycle 19.
4. len=0 with pattern=8'hA5: dout = 1,0,1,0,0,1,0,1 on cycles 1-8, done on cycle 9. Repeat with len=1, pattern=8'h01: single bit 1 on cycle 1, done on cycle 2.
5. start re-asserted on cycles 2-3 during a transfer is ignored, and output matches scenario 1. abort at cycle 2 gives IDLE with dout_valid=0 from cycle 3 and no done pulse.
6. reset asserted at cycle 3 of scenario 3 gives all outputs 0 from cycle 4. A new start at cycle 6 transmits correctly from cycle 7.
